// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl_pkg: shared state encoding, opcodes, ALU op codes and status bit indices for the SISC control unit
package sisc_ctrl_pkg;
   typedef enum logic [2:0] {
      S_START0, S_START1, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
   } state_t;
   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ALU = 4'b0001;
   localparam logic [3:0] OP_ALI = 4'b0010;
   localparam logic [3:0] OP_BRA = 4'b0100;
   localparam logic [3:0] OP_BRR = 4'b0101;
   localparam logic [3:0] OP_BNE = 4'b0110;
   localparam logic [3:0] OP_BNR = 4'b0111;
   localparam logic [3:0] OP_LOD = 4'b1000;
   localparam logic [3:0] OP_STR = 4'b1001;
   localparam logic [3:0] OP_HLT = 4'b1111;
   localparam logic [1:0] ALU_RR   = 2'b00;
   localparam logic [1:0] ALU_RI   = 2'b01;
   localparam logic [1:0] ALU_ADDR = 2'b10;
   localparam int STAT_Z = 3;
   localparam int STAT_N = 2;
   localparam int STAT_V = 1;
   localparam int STAT_C = 0;
   function automatic logic is_branch(input logic [3:0] op);
      return op == OP_BRA || op == OP_BRR || op == OP_BNE || op == OP_BNR;
   endfunction
endpackage

// File: rtl/sisc_br_cond.sv
// sisc_br_cond: combinational branch-condition evaluator
// Ports: opcode/mm/stat in; take_branch = PC should load the target, br_sel = 1 for PC-relative target
module sisc_br_cond
   import sisc_ctrl_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int MM_W   = 4,
   parameter int STAT_W = 4
) (
   input  logic [OP_W-1:0]   opcode,
   input  logic [MM_W-1:0]   mm,
   input  logic [STAT_W-1:0] stat,
   output logic              take_branch,
   output logic              br_sel
);
   logic w_any;
   assign w_any = |(mm & stat);
   // BNE/BNR invert the mask test, so an empty mask makes them unconditional
   assign take_branch = (opcode == OP_BRA || opcode == OP_BRR) ? w_any :
                        (opcode == OP_BNE || opcode == OP_BNR) ? ~w_any : 1'b0;
   assign br_sel = opcode == OP_BRR || opcode == OP_BNR;
endmodule

// File: rtl/sisc_ctrl.sv
// sisc_ctrl: multi-cycle SISC control FSM (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT)
// Ports: clk, rst_f (sync, active-high); opcode/mm/stat from IR and status register;
//        PC, IR, register file, ALU, status and data memory enables/selects; halted
module sisc_ctrl
   import sisc_ctrl_pkg::*;
#(
   parameter int OP_W   = 4,
   parameter int MM_W   = 4,
   parameter int STAT_W = 4
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic [OP_W-1:0]   opcode,
   input  logic [MM_W-1:0]   mm,
   input  logic [STAT_W-1:0] stat,
   output logic              pc_rst,
   output logic              pc_write,
   output logic              pc_sel,
   output logic              br_sel,
   output logic              ir_load,
   output logic              rd_sel,
   output logic [1:0]        alu_op,
   output logic              stat_en,
   output logic              dm_we,
   output logic              rf_we,
   output logic              wb_sel,
   output logic              halted
);
   state_t     r_state, w_next;
   logic       w_take, w_br_sel, w_str, w_lod, w_arith;
   logic [1:0] w_alu;
   sisc_br_cond #(.OP_W(OP_W), .MM_W(MM_W), .STAT_W(STAT_W)) u_br (
      .opcode(opcode), .mm(mm), .stat(stat), .take_branch(w_take), .br_sel(w_br_sel)
   );
   assign w_str   = opcode == OP_STR;
   assign w_lod   = opcode == OP_LOD;
   assign w_arith = opcode == OP_ALU || opcode == OP_ALI;
   assign w_alu   = (opcode == OP_ALI) ? ALU_RI : (w_lod || w_str) ? ALU_ADDR : ALU_RR;
   always_ff @(posedge clk)
      r_state <= rst_f ? S_START0 : w_next;
   always_comb begin
      w_next   = r_state;
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
      ir_load  = 1'b0;
      rd_sel   = 1'b0;
      alu_op   = ALU_RR;
      stat_en  = 1'b0;
      dm_we    = 1'b0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      halted   = 1'b0;
      case (r_state)
         S_START0: begin
            w_next = S_START1;
            pc_rst = 1'b1;
         end
         S_START1: w_next = S_START1 == r_state ? S_FETCH : S_START0;
         S_FETCH: begin
            w_next   = S_DECODE;
            ir_load  = 1'b1;
            pc_write = 1'b1;
         end
         S_DECODE: begin
            // PC already holds PC+1 here, so a relative target is based on it
            w_next   = S_EXECUTE;
            pc_write = w_take;
            pc_sel   = is_branch(opcode);
            br_sel   = w_br_sel;
         end
         S_EXECUTE: begin
            w_next = (opcode == OP_HLT) ? S_HALT : S_MEM;
            alu_op = w_alu;
            rd_sel = w_str;
         end
         S_MEM: begin
            w_next = S_WRITEBACK;
            alu_op = w_alu;
            rd_sel = w_str;
            dm_we  = w_str;
         end
         S_WRITEBACK: begin
            w_next  = S_FETCH;
            alu_op  = w_alu;
            rf_we   = w_arith || w_lod;
            wb_sel  = w_lod;
            stat_en = w_arith;
         end
         S_HALT: halted = 1'b1;
         default: w_next = S_START0;
      endcase
   end
endmodule

// File: tb/tb_sisc_ctrl.sv
// tb_sisc_ctrl: table-driven per-cycle check of every sisc_ctrl output plus reset/halt corner sequences
module tb_sisc_ctrl;
   logic        clk, rst_f;
   logic [3:0]  opcode, mm, stat;
   logic        pc_rst, pc_write, pc_sel, br_sel, ir_load, rd_sel;
   logic [1:0]  alu_op;
   logic        stat_en, dm_we, rf_we, wb_sel, halted;
   logic [12:0] w_out;
   int          n_cmp = 0;
   int          n_err = 0;
   // packed order: pc_rst pc_write pc_sel br_sel ir_load rd_sel alu_op[1:0] stat_en dm_we rf_we wb_sel halted
   localparam logic [12:0] E_0    = 13'h000;
   localparam logic [12:0] E_RST  = 13'h1000;
   localparam logic [12:0] E_FET  = 13'h0900;
   localparam logic [12:0] E_AWB  = 13'h0014;
   localparam logic [12:0] E_I    = 13'h0020;
   localparam logic [12:0] E_IWB  = 13'h0034;
   localparam logic [12:0] E_AD   = 13'h0040;
   localparam logic [12:0] E_LWB  = 13'h0046;
   localparam logic [12:0] E_SEX  = 13'h00C0;
   localparam logic [12:0] E_SMEM = 13'h00C8;
   localparam logic [12:0] E_BRT  = 13'h0E00;
   localparam logic [12:0] E_BRN  = 13'h0600;
   localparam logic [12:0] E_BAT  = 13'h0C00;
   localparam logic [12:0] E_BAN  = 13'h0400;
   localparam logic [12:0] E_HLT  = 13'h0001;
   typedef struct {
      logic        rst;
      logic [3:0]  op, m, s;
      logic [12:0] exp;
   } vec_t;
   vec_t tbl[$];
   sisc_ctrl dut (
      .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
      .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
      .ir_load(ir_load), .rd_sel(rd_sel), .alu_op(alu_op), .stat_en(stat_en),
      .dm_we(dm_we), .rf_we(rf_we), .wb_sel(wb_sel), .halted(halted)
   );
   assign w_out = {pc_rst, pc_write, pc_sel, br_sel, ir_load, rd_sel, alu_op,
                   stat_en, dm_we, rf_we, wb_sel, halted};
   always #5 clk = ~clk;
   function automatic void add(input logic r, input logic [3:0] op, m, s, input logic [12:0] e);
      tbl.push_back('{rst: r, op: op, m: m, s: s, exp: e});
   endfunction
   // one instruction: FETCH, DECODE, EXECUTE, MEM, WRITEBACK with the opcode held throughout
   function automatic void instr(input logic [3:0] op, m, s, input logic [12:0] d, x, me, w);
      add(0, op, m, s, E_FET);
      add(0, op, m, s, d);
      add(0, op, m, s, x);
      add(0, op, m, s, me);
      add(0, op, m, s, w);
   endfunction
   task automatic step(input logic r, input logic [3:0] op, m, s, input logic [12:0] e, input string nm);
      rst_f  = r;
      opcode = op;
      mm     = m;
      stat   = s;
      #1;
      n_cmp++;
      if (w_out !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, w_out, e);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      clk    = 1'b0;
      rst_f  = 1'b1;
      opcode = 4'h0;
      mm     = 4'h0;
      stat   = 4'h0;
      add(1, 4'h0, 4'h0, 4'h0, E_RST);
      add(0, 4'h0, 4'h0, 4'h0, E_RST);
      add(0, 4'h0, 4'h0, 4'h0, E_0);
      instr(4'h1, 4'h0, 4'h0, E_0,   E_0,   E_0,    E_AWB);
      instr(4'h2, 4'hF, 4'hF, E_0,   E_I,   E_I,    E_IWB);
      instr(4'h8, 4'h0, 4'h0, E_0,   E_AD,  E_AD,   E_LWB);
      instr(4'h9, 4'h0, 4'h0, E_0,   E_SEX, E_SMEM, E_AD);
      instr(4'h5, 4'h1, 4'h1, E_BRT, E_0,   E_0,    E_0);
      instr(4'h5, 4'h1, 4'h2, E_BRN, E_0,   E_0,    E_0);
      instr(4'h6, 4'h1, 4'h0, E_BAT, E_0,   E_0,    E_0);
      instr(4'h4, 4'h0, 4'hF, E_BAN, E_0,   E_0,    E_0);
      instr(4'h7, 4'h0, 4'hF, E_BRT, E_0,   E_0,    E_0);
      instr(4'hA, 4'hF, 4'hF, E_0,   E_0,   E_0,    E_0);
      instr(4'h0, 4'h3, 4'h3, E_0,   E_0,   E_0,    E_0);
      add(0, 4'hF, 4'h0, 4'h0, E_FET);
      add(0, 4'hF, 4'h0, 4'h0, E_0);
      add(0, 4'hF, 4'h0, 4'h0, E_0);
      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[i])
         step(tbl[i].rst, tbl[i].op, tbl[i].m, tbl[i].s, tbl[i].exp, $sformatf("tbl[%0d]", i));
      for (int i = 0; i < 20; i++)
         step(0, 4'(i), 4'(i * 3), 4'(~i), E_HLT, $sformatf("halt%0d", i));
      step(1, 4'h9, 4'h0, 4'h0, E_HLT, "halt_rst");
      step(0, 4'h9, 4'h0, 4'h0, E_RST, "str_start0");
      step(0, 4'h9, 4'h0, 4'h0, E_0,   "str_start1");
      step(0, 4'h9, 4'h0, 4'h0, E_FET, "str_fetch");
      step(0, 4'h9, 4'h0, 4'h0, E_0,   "str_decode");
      step(0, 4'h9, 4'h0, 4'h0, E_SEX, "str_exec");
      step(1, 4'h9, 4'h0, 4'h0, E_SMEM, "str_mem_rst");
      step(0, 4'h9, 4'h0, 4'h0, E_RST, "mem_rst_start0");
      step(0, 4'hF, 4'h0, 4'h0, E_0,   "mem_rst_start1");
      step(0, 4'hF, 4'h0, 4'h0, E_FET, "mem_rst_fetch");
      step(0, 4'hF, 4'h0, 4'h0, E_0,   "hlt_decode");
      step(1, 4'hF, 4'h0, 4'h0, E_0,   "hlt_exec_rst");
      step(0, 4'hF, 4'h0, 4'h0, E_RST, "hlt_rst_start0");
      step(0, 4'h1, 4'h0, 4'h0, E_0,   "hlt_rst_start1");
      step(0, 4'h1, 4'h0, 4'h0, E_FET, "hlt_rst_fetch");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
- Multi-cycle control unit for the SISC processor; sequences PC, IR, register file, ALU, status register and data memory.
- Fixed 5-state instruction cycle: FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
- Consumes opcode/mm fields from the IR and status flags. Drives every datapath enable/select.
- Instantiated inside sisc beside the datapath.

Parameters:
- OP_W, 4, opcode field width
- MM_W, 4, mask/modifier field width
- STAT_W, 4, status flag width (Z,N,V,C order fixed by datapath)

Ports:
- clk  input  1  system clock, rising edge
- rst_f  input  1  reset, synchronous, active-high
- opcode  input  OP_W  IR[31:28]
- mm  input  MM_W  IR[27:24], branch condition mask / ALU modifier
- stat  input  STAT_W  current status register flags
- pc_rst  output  1  clear PC
- pc_write  output  1  load PC
- pc_sel  output  1  0 = PC+1, 1 = branch target
- br_sel  output  1  0 = absolute target, 1 = PC-relative target
- ir_load  output  1  load IR from instruction memory
- rd_sel  output  1  register read port 2 selects rd (store data) instead of rt
- alu_op  output  2  00 reg-reg, 01 reg-imm, 10 address calc (base+imm), 11 unused
- stat_en  output  1  update status register
- dm_we  output  1  data memory write
- rf_we  output  1  register file write
- wb_sel  output  1  0 = ALU result, 1 = memory data
- halted  output  1  processor stopped

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Any rising clk edge with rst_f=1 forces state START0, including mid-instruction.
- States and transitions:
  - START0 -> START1 -> FETCH -> DECODE -> EXECUTE.
  - EXECUTE -> HALT if opcode is HLT, else -> MEM.
  - MEM -> WRITEBACK -> FETCH.
  - HALT -> HALT until reset.
- Outputs are combinational from the state register plus opcode/mm/stat. Every output defaults to 0 unless listed below.
- START0: pc_rst=1. This is the reset output state: all other outputs 0.
- START1: all outputs 0. One idle cycle so the PC settles.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE: evaluate the branch condition, take = |(mm & stat).
  - BRA 0100: pc_write=take, pc_sel=1, br_sel=0.
  - BRR 0101: pc_write=take, pc_sel=1, br_sel=1.
  - BNE 0110: pc_write=~take, pc_sel=1, br_sel=0.
  - BNR 0111: pc_write=~take, pc_sel=1, br_sel=1.
  - The relative target is computed from the already-incremented PC.
- EXECUTE, MEM, WRITEBACK: alu_op is held constant across all three states.
  - ALU 0001 -> 00
  - ALI 0010 -> 01
  - LOD 1000, STR 1001 -> 10
  - others -> 00
- EXECUTE, MEM: rd_sel=1 for STR.
- MEM: dm_we=1 for STR only, asserted for exactly one cycle.
- WRITEBACK:
  - rf_we=1 for ALU, ALI, LOD.
  - wb_sel=1 for LOD.
  - stat_en=1 for ALU, ALI.
- HALT: halted=1, all other outputs 0. stat and opcode are ignored.
- NOP 0000 and undefined opcodes (0011, 1010-1110) run the full 5 cycles with no side effects beyond the PC increment.
- Latency:
  - Every non-HLT instruction takes exactly 5 cycles, FETCH to FETCH.
  - First FETCH occurs 2 cycles after reset deasserts.
  - Branch outcome is known 1 cycle after FETCH.
- mm=0000 on BRA/BRR: never taken. mm=0000 on BNE/BNR: always taken.
- Simultaneous rst_f and HLT: reset wins.

Decomposition:
- Package sisc_ctrl_pkg holds:
  - state encoding: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT (3-bit)
  - opcode constants
  - alu_op codes
  - status bit indices
- One natural sub-module: sisc_br_cond, combinational. Inputs opcode, mm, stat; outputs take_branch and br_sel.

Test Plan:
- rst_f=1 for 2 edges then 0 -> pc_rst=1 while in START0. ir_load first asserts on the 2nd edge after release. All other outputs are 0 throughout reset.
- opcode=0001 -> in WRITEBACK (5th cycle), rf_we=1, stat_en=1, wb_sel=0. alu_op=00 in EXECUTE..WRITEBACK. dm_we is never asserted.
- opcode=1000, then opcode=1001:
  - LOD: alu_op=10, rf_we=1 and wb_sel=1 in WRITEBACK only.
  - STR: rd_sel=1 in EXECUTE/MEM, dm_we=1 for exactly 1 cycle in MEM, rf_we=0.
- opcode=0101, mm=0001:
  - stat=0001: DECODE drives pc_write=1, pc_sel=1, br_sel=1.
  - stat=0010: pc_write=0 in DECODE.
  - opcode=0110, mm=0001, stat=0000: pc_write=1, br_sel=0.
- opcode=1111 -> halted=1 from the cycle after EXECUTE. It stays high for 20 cycles with all enables 0 while opcode and stat toggle.
- Assert rst_f during MEM of a STR -> next cycle in START0, dm_we=0, pc_rst=1. Normal fetch resumes after release.
